// File: rtl/objects_mux_hit.sv
// Final pixel mux (missile > smiley > alien > background) with per-frame collision pulses and hit counter.
// Optional background flash after a player hit: define OBJECTS_MUX_HIT_FLASH_EN.
module objects_mux_hit #(
  parameter              FLASH_COLOR  = 8'hE0,
  parameter int unsigned FLASH_FRAMES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       startOfFrame,
  input  logic       smileyDrawingRequest,
  input  logic [7:0] smileyRGB,
  input  logic       missileDrawingRequest,
  input  logic [7:0] missileRGB,
  input  logic       alienDrawingRequest,
  input  logic [7:0] alienRGB,
  input  logic [7:0] backGroundRGB,
  output logic [7:0] RGBOut,
  output logic       playerHit,
  output logic       alienHit,
  output logic [7:0] hitCount
);

  if (FLASH_FRAMES < 1 || FLASH_FRAMES > 15 || FLASH_COLOR > 255) begin : g_bad_cfg
    $error("objects_mux_hit: FLASH_FRAMES must be 1..15 and FLASH_COLOR must fit 8 bits");
  end

  logic       pa, ma;
  logic       player_hit_q, alien_hit_q;
  logic [7:0] hit_cnt_q;
  logic [7:0] rgb_q, rgb_d, bg_rgb;
  logic       pa_ovl, ma_ovl;

  assign pa_ovl = smileyDrawingRequest & alienDrawingRequest;
  assign ma_ovl = missileDrawingRequest & alienDrawingRequest;

`ifdef OBJECTS_MUX_HIT_FLASH_EN
  typedef enum logic {IDLE, FLASH} flash_state_t;

  flash_state_t state_q, state_d;
  logic [3:0]   frm_q, frm_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      frm_q   <= '0;
    end else begin
      state_q <= state_d;
      frm_q   <= frm_d;
    end
  end

  // A fresh player hit restarts the flash even if a frame boundary coincides.
  always_comb begin
    state_d = state_q;
    frm_d   = frm_q;
    case (state_q)
      IDLE: begin
        if (player_hit_q) begin
          state_d = FLASH;
          frm_d   = 4'(FLASH_FRAMES);
        end
      end
      FLASH: begin
        if (player_hit_q) begin
          frm_d = 4'(FLASH_FRAMES);
        end else if (startOfFrame) begin
          frm_d = frm_q - 4'd1;
          if (frm_q == 4'd1) state_d = IDLE;
        end
      end
    endcase
  end

  assign bg_rgb = (state_q == FLASH) ? 8'(FLASH_COLOR) : backGroundRGB;
`else
  assign bg_rgb = backGroundRGB;
`endif

  always_comb begin
    rgb_d = bg_rgb;
    if (missileDrawingRequest)     rgb_d = missileRGB;
    else if (smileyDrawingRequest) rgb_d = smileyRGB;
    else if (alienDrawingRequest)  rgb_d = alienRGB;
  end

  // At a frame boundary the old flags are reported and the boundary pixel seeds the new frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      rgb_q        <= '0;
      pa           <= 1'b0;
      ma           <= 1'b0;
      player_hit_q <= 1'b0;
      alien_hit_q  <= 1'b0;
      hit_cnt_q    <= '0;
    end else begin
      rgb_q <= rgb_d;
      if (startOfFrame) begin
        player_hit_q <= pa;
        alien_hit_q  <= ma;
        pa           <= pa_ovl;
        ma           <= ma_ovl;
      end else begin
        player_hit_q <= 1'b0;
        alien_hit_q  <= 1'b0;
        pa           <= pa | pa_ovl;
        ma           <= ma | ma_ovl;
      end
      if (alien_hit_q && hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + 8'd1;
    end
  end

  assign RGBOut    = rgb_q;
  assign playerHit = player_hit_q;
  assign alienHit  = alien_hit_q;
  assign hitCount  = hit_cnt_q;

endmodule
